serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder with a start/done handshake, the additive counterpart of the team's parallel ripple subtractor. It consumes one operand bit pair per clock, LSB first, through a single full-adder slice, and produces the sum, carry-out and two's-complement overflow. It sits in the datapath wherever a small, area-cheap adder is acceptable at WIDTH-cycle latency.

## Interface
- WIDTH, 4, operand and result width in bits; legal values are ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled on a rising edge and accepted only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  sum (a + b + cin) mod 2^WIDTH; registered.
- cout  output  1  carry out of the MSB; registered.
- OverFlow  output  1  signed overflow, equal to the carry into the MSB XOR the carry out of the MSB; registered.

## Operation
- State machine has two states:
  - IDLE: wait for start.
  - RUN: one bit is processed per cycle.
- Internal registers:
  - a_sh, b_sh: operand shift registers, shifted right each RUN cycle.
  - c: running carry.
  - c_prev: carry into the current bit.
  - s_sh: sum shift register.
  - cnt: bit counter, width clog2(WIDTH).
- IDLE, start=1 on an edge:
  - Load a_sh=a, b_sh=b, c=cin, cnt=0, s_sh=0.
  - Move to RUN.
  - Set busy=1.
- RUN, each edge:
  - Compute s = a_sh[0]^b_sh[0]^c.
  - Update c ← majority(a_sh[0], b_sh[0], c).
  - Update c_prev ← old c.
  - Shift s into the MSB of s_sh (shift right).
  - Increment cnt.
- RUN, final edge (cnt = WIDTH-1):
  - Write the completed sum to result.
  - Write the new carry to cout.
  - Write old c XOR new c to OverFlow.
  - Set done=1 and busy=0.
  - Return to IDLE.
- done is forced to 0 on every edge on which no operation finishes.
- result, cout and OverFlow change only on a completing edge. They hold their value until the next completion.
- start while busy=1 is ignored. No queueing; the operands are not re-sampled.
- Subtraction a - b is obtained by driving b=~b_orig and cin=1. The outputs then use the same cout/OverFlow convention as the team's ripple subtractor.

## Timing
- Reset (rst_n=0, asynchronous, any time):
  - State = IDLE.
  - busy=0, done=0, result=0, cout=0, OverFlow=0.
  - All internal registers = 0.
  - An operation in progress is aborted and produces no done.
- Leaving reset: the first edge with rst_n=1 may accept start.
- Latency, with start accepted on edge E0:
  - busy=1 after E0 through E(WIDTH-1).
  - At E(WIDTH), busy drops, done=1 and outputs are valid.
  - Start to result is WIDTH+1 edges.
  - Throughput is one operation per WIDTH+1 cycles.
- Back-to-back: start held or asserted during the done cycle is accepted on the next edge (state is IDLE), with no idle bubble beyond the done cycle.
- Operand inputs a, b, cin may change freely after the accepting edge without affecting the operation.
- Wrap-around: result is always mod 2^WIDTH. The carry beyond the MSB appears only on cout.

## Test plan
- Reset, then start with a=3, b=4, cin=0 (WIDTH=4):
  - busy high for 4 cycles.
  - done pulses 5 edges after start.
  - result=7, cout=0, OverFlow=0.
- Overflow and carry combinations (WIDTH=4), each run separately with cin=0 unless stated:
  - a=7, b=1: result=8, cout=0, OverFlow=1.
  - a=15, b=1: result=0, cout=1, OverFlow=0.
  - a=8, b=8: result=0, cout=1, OverFlow=1.
- a=5, b=10, cin=1: result=0, cout=1, OverFlow=0.
- Subtraction use, a=2 with b=~5=10 and cin=1: result=13 (-3), cout=0, OverFlow=0.
- Protocol cases:
  - Start pulses at cycles 1 and 2 of busy with different operands are ignored; the first operation's result is unchanged.
  - Start asserted during the done cycle begins a second operation immediately. Its done follows 5 edges later.
  - Previous outputs hold until then.
- Reset mid-operation: rst_n low asynchronously in cycle 2 of RUN:
  - All outputs go to 0 immediately.
  - No done pulse follows.
  - A fresh start after release gives the correct result.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with a start/done handshake.
// One operand bit pair is consumed per clock, LSB first, through a single
// full-adder slice. The sum, carry-out and two's-complement overflow are
// registered on the completing edge and held until the next completion.
//
// Ports:
//   clk      clock; all state updates on the rising edge
//   rst_n    asynchronous active-low reset
//   start    request; accepted only while idle
//   a, b     operands, captured on the accepting edge
//   cin      carry-in, captured on the accepting edge
//   busy     high while an operation is in progress
//   done     one-cycle completion pulse
//   result   (a + b + cin) mod 2^WIDTH
//   cout     carry out of the MSB
//   OverFlow carry into the MSB XOR carry out of the MSB
module serial_adder #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             OverFlow
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic             c_q, c_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   // Full-adder slice on the current LSBs.
   logic s;
   logic c_new;
   logic c_prev;  // carry into the bit being processed

   assign c_prev = c_q;
   assign s      = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
   assign c_new  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         s_sh_q   <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         s_sh_q   <= s_sh_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      s_sh_d   = s_sh_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               c_d     = cin;
               cnt_d   = '0;
               s_sh_d  = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            c_d    = c_new;
            s_sh_d = {s, s_sh_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               // The final sum bit lands in the MSB on this same edge.
               result_d = {s, s_sh_q[WIDTH-1:1]};
               cout_d   = c_new;
               ovf_d    = c_prev ^ c_new;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end
      endcase
   end

   assign busy     = (state_q == StRun);
   assign done     = done_q;
   assign result   = result_q;
   assign cout     = cout_q;
   assign OverFlow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic model.
module tb_serial_adder;

   localparam int unsigned W = 4;
   localparam int Mod  = 1 << W;
   localparam int Half = 1 << (W - 1);

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         OverFlow;

   int n_checks;
   int n_fail;

   logic [W-1:0] prev_res;
   logic         prev_cout;
   logic         prev_ovf;

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .OverFlow (OverFlow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: unsigned sum for result/cout, signed range test for overflow.
   function automatic void model(input int av, input int bv, input int cv,
                                 output int r, output int co, output int ov);
      int u;
      int sa;
      int sb;
      int ss;
      u  = av + bv + cv;
      r  = u % Mod;
      co = (u >= Mod) ? 1 : 0;
      sa = (av >= Half) ? av - Mod : av;
      sb = (bv >= Half) ? bv - Mod : bv;
      ss = sa + sb + cv;
      ov = (ss > Half - 1 || ss < -Half) ? 1 : 0;
   endfunction

   // Starts one operation from the current time (off-edge), runs it to done
   // and checks latency, busy, output hold and final outputs. With poke set,
   // start is re-asserted with other operands on busy cycles 1 and 2.
   task automatic run_op(input int av, input int bv, input int cv, input bit poke);
      int  er;
      int  ec;
      int  eo;
      int  k;
      bit  seen;
      model(av, bv, cv, er, ec, eo);
      a     = W'(av);
      b     = W'(bv);
      cin   = 1'(cv);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      seen  = 1'b0;
      k     = 0;
      while (!seen && k < 3 * W) begin
         check("busy_run", int'(busy), 1);
         check("hold_result", int'(result), int'(prev_res));
         check("hold_cout", int'(cout), int'(prev_cout));
         check("hold_ovf", int'(OverFlow), int'(prev_ovf));
         if (poke && k < 2) begin
            start = 1'b1;
            a     = W'(~av);
            b     = W'(av + 3);
            cin   = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         k++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check("done_seen", int'(seen), 1);
      check("latency", k, int'(W));
      check("busy_done", int'(busy), 0);
      check("result", int'(result), er);
      check("cout", int'(cout), ec);
      check("ovf", int'(OverFlow), eo);
      prev_res  = W'(er);
      prev_cout = 1'(ec);
      prev_ovf  = 1'(eo);
   endtask

   initial begin
      int dcount;
      int gap;
      n_checks  = 0;
      n_fail    = 0;
      prev_res  = '0;
      prev_cout = 1'b0;
      prev_ovf  = 1'b0;
      rst_n     = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;

      #2;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 0);
      check("rst_cout", int'(cout), 0);
      check("rst_ovf", int'(OverFlow), 0);
      #10;
      rst_n = 1'b1;

      // Directed cases, issued back-to-back from each done cycle.
      run_op(3, 4, 0, 1'b0);
      run_op(7, 1, 0, 1'b0);
      run_op(15, 1, 0, 1'b0);
      run_op(8, 8, 0, 1'b0);
      run_op(5, 10, 1, 1'b0);
      run_op(2, 10, 1, 1'b0);
      run_op(6, 5, 0, 1'b1);

      // Reset during the second RUN cycle.
      a     = W'(9);
      b     = W'(3);
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_result", int'(result), 0);
      check("midrst_cout", int'(cout), 0);
      check("midrst_ovf", int'(OverFlow), 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      prev_res  = '0;
      prev_cout = 1'b0;
      prev_ovf  = 1'b0;
      dcount    = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
      end
      check("midrst_no_done", dcount, 0);
      check("midrst_idle", int'(busy), 0);
      run_op(9, 3, 0, 1'b0);

      // Randomized operations with random idle gaps.
      for (int n = 0; n < 40; n++) begin
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            check("done_pulse", int'(done), 0);
         end
         run_op(int'($urandom_range(0, Mod - 1)), int'($urandom_range(0, Mod - 1)),
                int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
